// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory request arbiter.
// Holds the state enum, the default widths and the index-width helper.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_ADDR_W         = 4;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    // Width needed to hold an index 0..n-1, never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_pick.sv
// Combinational round-robin picker: the first request above last_grant wins,
// otherwise the lowest request wins.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] masked;

    function automatic logic [NUM_REQ-1:0] lowest(input logic [NUM_REQ-1:0] v);
        return v & (~v + NUM_REQ'(1));
    endfunction

    // NOTE: every always_comb output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mask[i] = (i > int'(last_grant));
        end
    end

    assign masked = req & mask;
    assign winner = (masked != '0) ? lowest(masked) : lowest(req);
    assign valid  = |req;

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory port between NUM_REQ requesters.
// Define MEM_ARB_TIMEOUT_EN to abort accesses that stay BUSY for TIMEOUT_CYCLES cycles.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        up_req_i,
    input  logic [NUM_REQ-1:0]        up_rnw_i,
    input  logic [NUM_REQ*ADDR_W-1:0] up_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] up_wdata_i,
    output logic [NUM_REQ-1:0]        up_ready_o,
    output logic [DATA_W-1:0]         up_rdata_o,
    output logic                      up_err_o,
    output logic                      mem_req_o,
    output logic                      mem_rnw_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    input  logic                      mem_ready_i,
    input  logic [DATA_W-1:0]         mem_rdata_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      busy_o
);

    localparam int IDX_W = idx_w(NUM_REQ);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic               win_valid;
    logic               timeout;
    logic               done;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (up_req_i),
        .last_grant (last_grant),
        .winner     (win_oh),
        .valid      (win_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) win_idx = IDX_W'(i);
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = idx_w(TIMEOUT_CYCLES + 1);

    // busy_cnt + 1 is the number of BUSY cycles including the current one.
    logic [CNT_W-1:0] busy_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)               busy_cnt <= '0;
        else if (state == IDLE)  busy_cnt <= '0;
        else                     busy_cnt <= busy_cnt + CNT_W'(1);
    end

    // A memory completion in the last allowed cycle takes precedence over the abort.
    assign timeout    = (state == BUSY) && (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !mem_ready_i;
    assign up_rdata_o = timeout ? '0 : mem_rdata_i;
`else
    assign timeout    = 1'b0;
    assign up_rdata_o = mem_rdata_i;
`endif

    assign done = (state == BUSY) && (mem_ready_i || timeout);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_valid) state_nxt = BUSY;
            BUSY:    if (done)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Captured fields are loaded only on the grant edge, so upstream changes during BUSY are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_o     <= '0;
            last_grant  <= IDX_W'(NUM_REQ - 1);
            mem_rnw_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else if (state == IDLE && win_valid) begin
            grant_o     <= win_oh;
            last_grant  <= win_idx;
            mem_rnw_o   <= up_rnw_i[win_idx];
            mem_addr_o  <= up_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
            mem_wdata_o <= up_wdata_i[int'(win_idx)*DATA_W +: DATA_W];
        end else if (done) begin
            grant_o     <= '0;
        end
    end

    // Leaving BUSY always passes through IDLE, which gives the mandatory idle bubble.
    assign mem_req_o  = (state == BUSY);
    assign busy_o     = (state == BUSY);
    assign up_ready_o = grant_o & {NUM_REQ{done}};
    assign up_err_o   = timeout;

endmodule
